dma_xfer_sched: RTL and testbench
=================================

Name: dma_xfer_sched

Overview:
- Transfer scheduler for one DMA channel. Sits between the register front-end and the AXI4 master read/write engines, around the channel's sync FIFO.
- Splits a transfer of N beats into AXI bursts. Each burst is capped by MAX_BURST and never crosses a 4 KB boundary.
- Issues a read burst (AR) only when the FIFO has room for the whole burst.
- Issues a write burst (AW) only when the FIFO already holds the whole burst. It then tracks W beats and the B response.

Parameters:
- DW, 32, data width in bits; bytes per beat BPB = DW/8 (a power of 2).
- AW_W, 32, address width.
- LW, 16, width of the transfer length in beats.
- DEPTH, 16, depth of the attached FIFO. Usable capacity is DEPTH-1.
- MAX_BURST, 8, maximum beats per burst; range 1..min(256, DEPTH-1).

Ports:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- start  in  1  one-cycle pulse that launches a transfer; ignored while busy=1
- src_addr  in  AW_W  source byte address, BPB-aligned
- dst_addr  in  AW_W  destination byte address, BPB-aligned
- len  in  LW  total beats
- fifo_cnt  in  clogb2(DEPTH)  current FIFO occupancy
- ar_valid  out  1  read address valid
- ar_ready  in  1  read address ready
- ar_addr  out  AW_W  read burst address
- ar_len  out  8  read beats-1
- r_beat  in  1  one R beat was pushed into the FIFO this cycle
- aw_valid  out  1  write address valid
- aw_ready  in  1  write address ready
- aw_addr  out  AW_W  write burst address
- aw_len  out  8  write beats-1
- w_active  out  1  W engine may pop the FIFO and drive W beats
- w_beat  in  1  one W beat handshaked (FIFO popped) this cycle
- w_last  out  1  the next W beat is the last beat of the current burst
- b_valid  in  1  write response valid
- b_ready  out  1  write response ready
- b_resp  in  2  write response code
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- err  out  1  sticky error; set by any nonzero b_resp, cleared by start

Behaviour:
- Reset (async): every output is 0. Both FSMs are in IDLE. All counters are 0.
- start while busy=0:
  - latches the source address, destination address, read-remaining = len and write-remaining = len;
  - sets busy=1 on the next edge and clears err.
- len=0: done=1 one cycle after start, busy stays 0, and no AR or AW is issued.
- Burst size rule, computed from the current address A and remaining count REM:
  - B = min(REM, MAX_BURST, (4096 - A[11:0]) / BPB);
  - the *_len output is B-1.
  - B is computed combinationally, then registered on entry to the AR or AW state.
- Read FSM:
  - R_IDLE goes to R_CHK when a transfer starts.
  - R_CHK goes to R_AR when fifo_cnt + B <= DEPTH-1. Only one read burst is outstanding at a time, so the FIFO level alone is a safe credit.
  - R_AR holds ar_valid=1 with ar_addr and ar_len stable until ar_ready, then goes to R_DATA.
  - R_DATA counts r_beat until B beats have arrived. At that point:
    - the read address advances by B*BPB and read-remaining decreases by B;
    - the FSM goes to R_CHK if read-remaining is nonzero, otherwise to R_IDLE.
- Write FSM:
  - W_IDLE goes to W_CHK when a transfer starts.
  - W_CHK goes to W_AW when fifo_cnt >= B.
  - W_AW holds aw_valid=1 until aw_ready, then goes to W_DATA.
  - W_DATA holds w_active=1 and counts w_beat. w_last=1 while the beat count equals B-1. After the B-th beat:
    - w_active drops on the next cycle;
    - the FSM goes to W_RESP.
  - W_RESP holds b_ready=1. On b_valid:
    - err is set if b_resp != 0;
    - the write address advances and write-remaining decreases by B;
    - the FSM goes to W_CHK if write-remaining is nonzero, otherwise to W_DONE.
- Completion: W_DONE while the read FSM is in R_IDLE gives done=1 for one cycle. busy=0 on the same edge, and both FSMs return to IDLE.
- r_beat or w_beat outside R_DATA or W_DATA is ignored.
- Beats beyond B are ignored; no counter overflows.
- Read and write bursts overlap freely. Simultaneous ar and aw handshakes in the same cycle are legal.
- An error does not abort the transfer; all remaining bursts are still issued.
- An async reset in mid-transfer returns everything to the reset state immediately. Any outstanding AXI transactions are the system's responsibility.
- Address arithmetic is modulo 2^AW_W. Counters are LW bits wide.

Test Plan:
- len=20, MAX_BURST=8, src=0x1000, dst=0x2000, ready always 1, FIFO model → AR bursts of 8/8/4 at 0x1000/0x1020/0x1040, AW bursts at 0x2000/0x2020/0x2040, exactly 20 w_beat, one done pulse, err=0.
- src=0x0FF8 (DW=32), len=6 → ar_len=1 at 0x0FF8, then ar_len=3 at 0x1000; no burst crosses 4 KB.
- fifo_cnt held at 12 with DEPTH=16 and B=8 → ar_valid stays 0 until fifo_cnt <= 7. fifo_cnt = 3 with B=4 → aw_valid stays 0 until fifo_cnt >= 4.
- ar_ready held low for 5 cycles → ar_valid stays high with ar_addr and ar_len stable, and the beat count is unchanged.
- Second burst gets b_resp=2'b10 → err=1 sticky, the transfer still completes with done. A new start clears err.
- Reset asserted mid R_DATA → all outputs 0 asynchronously. start after release runs a clean transfer. len=0 → done one cycle after start, no ar_valid or aw_valid.

Source files
------------

// File: rtl/dma_xfer_sched.sv
// DMA channel transfer scheduler: splits a transfer into 4KB-safe AXI
// bursts, gating reads on FIFO room and writes on FIFO fill.
module dma_xfer_sched #(
  parameter int DW        = 32,
  parameter int AW_W      = 32,
  parameter int LW        = 16,
  parameter int DEPTH     = 16,
  parameter int MAX_BURST = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [AW_W-1:0]          src_addr,
  input  logic [AW_W-1:0]          dst_addr,
  input  logic [LW-1:0]            len,
  input  logic [$clog2(DEPTH)-1:0] fifo_cnt,
  output logic                     ar_valid,
  input  logic                     ar_ready,
  output logic [AW_W-1:0]          ar_addr,
  output logic [7:0]               ar_len,
  input  logic                     r_beat,
  output logic                     aw_valid,
  input  logic                     aw_ready,
  output logic [AW_W-1:0]          aw_addr,
  output logic [7:0]               aw_len,
  output logic                     w_active,
  input  logic                     w_beat,
  output logic                     w_last,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [1:0]               b_resp,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int BSH = $clog2(DW/8);

  typedef enum logic [1:0] {
    R_IDLE, R_CHK, R_AR, R_DATA
  } rd_st_e;

  typedef enum logic [2:0] {
    W_IDLE, W_CHK, W_AW, W_DATA, W_RESP, W_DONE
  } wr_st_e;

  rd_st_e          r_rst, w_rnxt;
  wr_st_e          r_wst, w_wnxt;
  logic [AW_W-1:0] r_raddr, r_waddr;
  logic [LW-1:0]   r_rrem, r_wrem;
  logic [7:0]      r_arlen, r_awlen;
  logic [7:0]      r_rcnt, r_wcnt;
  logic            r_busy, r_done, r_err;

  logic [8:0] w_rb, w_wb, w_rbn, w_wbn;
  logic       w_start, w_go, w_rfit, w_wfit;
  logic       w_rlast, w_wlast, w_bhs, w_fin;

  // beats = min(remaining, MAX_BURST, beats left in this 4KB page)
  function automatic logic [8:0] f_burst(
    input logic [11:0]   a,
    input logic [LW-1:0] rem
  );
    logic [31:0] room;
    logic [31:0] b;
    room = (32'd4096 - {20'd0, a}) >> BSH;
    b    = 32'(MAX_BURST);
    if (room < b) b = room;
    if (32'(rem) < b) b = 32'(rem);
    return b[8:0];
  endfunction

  assign w_start = start & ~r_busy;
  assign w_go    = w_start & (len != '0);
  assign w_rb    = f_burst(r_raddr[11:0], r_rrem);
  assign w_wb    = f_burst(r_waddr[11:0], r_wrem);
  assign w_rbn   = {1'b0, r_arlen} + 9'd1;
  assign w_wbn   = {1'b0, r_awlen} + 9'd1;
  assign w_rfit  = (32'(fifo_cnt) + 32'(w_rb))
                   <= 32'(DEPTH-1);
  assign w_wfit  = 32'(fifo_cnt) >= 32'(w_wb);
  assign w_rlast = (r_rst == R_DATA) & r_beat
                   & (r_rcnt == r_arlen);
  assign w_wlast = (r_wst == W_DATA) & w_beat
                   & (r_wcnt == r_awlen);
  assign w_bhs   = (r_wst == W_RESP) & b_valid;
  assign w_fin   = (r_wst == W_DONE) & (r_rst == R_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rst <= R_IDLE;
      r_wst <= W_IDLE;
    end else begin
      r_rst <= w_rnxt;
      r_wst <= w_wnxt;
    end
  end

  always_comb begin
    w_rnxt = r_rst;
    unique case (r_rst)
      R_IDLE: if (w_go)     w_rnxt = R_CHK;
      R_CHK:  if (w_rfit)   w_rnxt = R_AR;
      R_AR:   if (ar_ready) w_rnxt = R_DATA;
      R_DATA:
        if (w_rlast)
          w_rnxt = (r_rrem == LW'(w_rbn)) ?
                   R_IDLE : R_CHK;
      default: w_rnxt = R_IDLE;
    endcase
  end

  always_comb begin
    w_wnxt = r_wst;
    unique case (r_wst)
      W_IDLE: if (w_go)     w_wnxt = W_CHK;
      W_CHK:  if (w_wfit)   w_wnxt = W_AW;
      W_AW:   if (aw_ready) w_wnxt = W_DATA;
      W_DATA: if (w_wlast)  w_wnxt = W_RESP;
      W_RESP:
        if (b_valid)
          w_wnxt = (r_wrem == LW'(w_wbn)) ?
                   W_DONE : W_CHK;
      W_DONE: if (w_fin)    w_wnxt = W_IDLE;
      default: w_wnxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_raddr <= '0;
      r_rrem  <= '0;
      r_arlen <= '0;
      r_rcnt  <= '0;
    end else begin
      if (w_go) begin
        r_raddr <= src_addr;
        r_rrem  <= len;
      end
      if (r_rst == R_CHK && w_rfit)
        r_arlen <= w_rb[7:0] - 8'd1;
      if (w_rlast) begin
        r_rcnt  <= '0;
        r_raddr <= r_raddr + (AW_W'(w_rbn) << BSH);
        r_rrem  <= r_rrem - LW'(w_rbn);
      end else if (r_rst == R_DATA && r_beat) begin
        r_rcnt  <= r_rcnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_waddr <= '0;
      r_wrem  <= '0;
      r_awlen <= '0;
      r_wcnt  <= '0;
    end else begin
      if (w_go) begin
        r_waddr <= dst_addr;
        r_wrem  <= len;
      end
      if (r_wst == W_CHK && w_wfit)
        r_awlen <= w_wb[7:0] - 8'd1;
      if (w_wlast)
        r_wcnt <= '0;
      else if (r_wst == W_DATA && w_beat)
        r_wcnt <= r_wcnt + 8'd1;
      if (w_bhs) begin
        r_waddr <= r_waddr + (AW_W'(w_wbn) << BSH);
        r_wrem  <= r_wrem - LW'(w_wbn);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= (w_start & (len == '0)) | w_fin;
      if (w_go)
        r_busy <= 1'b1;
      else if (w_fin)
        r_busy <= 1'b0;
      if (w_start)
        r_err <= 1'b0;
      else if (w_bhs && b_resp != 2'b00)
        r_err <= 1'b1;
    end
  end

  always_comb begin
    ar_valid = (r_rst == R_AR);
    ar_addr  = ar_valid ? r_raddr : '0;
    ar_len   = ar_valid ? r_arlen : '0;
    aw_valid = (r_wst == W_AW);
    aw_addr  = aw_valid ? r_waddr : '0;
    aw_len   = aw_valid ? r_awlen : '0;
    w_active = (r_wst == W_DATA);
    w_last   = w_active & (r_wcnt == r_awlen);
    b_ready  = (r_wst == W_RESP);
    busy     = r_busy;
    done     = r_done;
    err      = r_err;
  end

endmodule

// File: tb/tb_dma_xfer_sched.sv
// Randomized bench for dma_xfer_sched: FIFO/AXI responder plus a
// burst-list reference model built from the 4KB/MAX_BURST split rule.
module tb_dma_xfer_sched;

  localparam int DEPTH = 16;
  localparam int MAXB  = 8;
  localparam int BPB   = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] len;
  logic [3:0]  fifo_cnt;
  logic        ar_valid, ar_ready;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic        r_beat;
  logic        aw_valid, aw_ready;
  logic [31:0] aw_addr;
  logic [7:0]  aw_len;
  logic        w_active, w_beat, w_last;
  logic        b_valid, b_ready;
  logic [1:0]  b_resp;
  logic        busy, done, err;

  always #5 clk = ~clk;

  dma_xfer_sched #(
    .DW(32), .AW_W(32), .LW(16),
    .DEPTH(DEPTH), .MAX_BURST(MAXB)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .fifo_cnt(fifo_cnt),
    .ar_valid(ar_valid), .ar_ready(ar_ready),
    .ar_addr(ar_addr), .ar_len(ar_len),
    .r_beat(r_beat),
    .aw_valid(aw_valid), .aw_ready(aw_ready),
    .aw_addr(aw_addr), .aw_len(aw_len),
    .w_active(w_active), .w_beat(w_beat),
    .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready),
    .b_resp(b_resp),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    logic [31:0] a;
    logic [7:0]  l;
  } burst_t;

  burst_t exp_ar[$];
  burst_t exp_aw[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [87:0] outs();
    return {ar_valid, aw_valid, w_active, w_last,
            b_ready, busy, done, err,
            ar_addr, ar_len, aw_addr, aw_len};
  endfunction

  task automatic set_idle();
    start = 0; src_addr = 0; dst_addr = 0; len = 0;
    fifo_cnt = 0; ar_ready = 0; r_beat = 0;
    aw_ready = 0; w_beat = 0; b_valid = 0; b_resp = 0;
  endtask

  task automatic do_reset();
    rstn = 0;
    set_idle();
    repeat (2) @(negedge clk);
    rstn = 1;
    @(negedge clk);
  endtask

  task automatic plan(input logic [31:0] s,
                      input logic [31:0] d,
                      input int n);
    burst_t e;
    logic [31:0] a;
    int rem, room, b;
    exp_ar.delete();
    exp_aw.delete();
    for (int k = 0; k < 2; k++) begin
      a = (k == 0) ? s : d;
      rem = n;
      while (rem > 0) begin
        room = (4096 - int'(a[11:0])) / BPB;
        b = rem;
        if (b > MAXB) b = MAXB;
        if (b > room) b = room;
        e.a = a;
        e.l = 8'(b - 1);
        if (k == 0) exp_ar.push_back(e);
        else exp_aw.push_back(e);
        a = a + 32'(b * BPB);
        rem = rem - b;
      end
    end
  endtask

  task automatic start_pulse(input logic [31:0] s,
                             input logic [31:0] d,
                             input int n);
    src_addr = s; dst_addr = d; len = 16'(n);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic run_xfer(input logic [31:0] s,
                          input logic [31:0] d,
                          input int n, input int bad,
                          input int pr);
    burst_t e;
    int fcnt, rpend, wlen, widx, nw, bidx, naw, gcyc;
    bit lr, lw, win, bpend, got, xerr;
    plan(s, d, n);
    naw = exp_aw.size();
    xerr = (bad >= 0) && (bad < naw);
    fcnt = 0; rpend = 0; wlen = 0; widx = 0;
    nw = 0; bidx = 0; gcyc = -1;
    lr = 0; lw = 0; win = 0; bpend = 0; got = 0;
    fifo_cnt = 0;
    start_pulse(s, d, n);
    if (n > 0) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_after_start got %b want 1",
                 busy);
      end
    end
    for (int cyc = 0; cyc < 4000 && !got; cyc++) begin
      fcnt = fcnt + int'(lr) - int'(lw);
      fifo_cnt = 4'(fcnt);
      ar_ready = 0; r_beat = 0; aw_ready = 0;
      w_beat = 0; b_valid = 0; b_resp = 0;
      if (done) begin
        got = 1;
        gcyc = cyc;
      end else begin
        ar_ready = int'($urandom_range(99)) < pr;
        r_beat = (rpend > 0) &&
                 (int'($urandom_range(99)) < pr);
        if (r_beat) rpend--;
        if (ar_valid && ar_ready) begin
          checks++;
          if (exp_ar.size() == 0) begin
            errors++;
            $display("FAIL ar_extra got %h/%0d want none",
                     ar_addr, ar_len);
          end else begin
            e = exp_ar.pop_front();
            if ({ar_addr, ar_len} !== {e.a, e.l}) begin
              errors++;
              $display("FAIL ar_burst got %h/%0d want %h/%0d",
                       ar_addr, ar_len, e.a, e.l);
            end
          end
          checks++;
          if (fcnt + int'(ar_len) + 1 > DEPTH - 1) begin
            errors++;
            $display("FAIL ar_credit got fifo %0d len %0d",
                     fcnt, ar_len);
          end
          rpend += int'(ar_len) + 1;
        end
        aw_ready = int'($urandom_range(99)) < pr;
        if (aw_valid && aw_ready) begin
          checks++;
          if (exp_aw.size() == 0) begin
            errors++;
            $display("FAIL aw_extra got %h/%0d want none",
                     aw_addr, aw_len);
          end else begin
            e = exp_aw.pop_front();
            if ({aw_addr, aw_len} !== {e.a, e.l}) begin
              errors++;
              $display("FAIL aw_burst got %h/%0d want %h/%0d",
                       aw_addr, aw_len, e.a, e.l);
            end
          end
          checks++;
          if (fcnt < int'(aw_len) + 1) begin
            errors++;
            $display("FAIL aw_credit got fifo %0d len %0d",
                     fcnt, aw_len);
          end
          win = 1; widx = 0;
          wlen = int'(aw_len) + 1;
        end else if (w_active) begin
          checks++;
          if (!win) begin
            errors++;
            $display("FAIL w_active got 1 want 0");
          end else if (fcnt > 0 &&
                       int'($urandom_range(99)) < pr) begin
            w_beat = 1;
            checks++;
            if (w_last !== (widx == wlen - 1)) begin
              errors++;
              $display("FAIL w_last got %b want %b",
                       w_last, widx == wlen - 1);
            end
            widx++; nw++;
            if (widx == wlen) begin
              win = 0;
              bpend = 1;
            end
          end
        end
        if (b_ready && bpend &&
            int'($urandom_range(99)) < pr) begin
          b_valid = 1;
          b_resp = (bidx == bad) ? 2'b10 : 2'b00;
          bidx++;
          bpend = 0;
        end
      end
      lr = r_beat; lw = w_beat;
      if (!got) @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL done_timeout got 0 want 1");
    end
    checks++;
    if (exp_ar.size() != 0 || exp_aw.size() != 0) begin
      errors++;
      $display("FAIL bursts_left got ar %0d aw %0d want 0",
               exp_ar.size(), exp_aw.size());
    end
    checks++;
    if (nw != n || bidx != naw) begin
      errors++;
      $display("FAIL w_count got %0d/%0d want %0d/%0d",
               nw, bidx, n, naw);
    end
    checks++;
    if (busy !== 1'b0 || err !== xerr) begin
      errors++;
      $display("FAIL end_state got busy %b err %b want 0 %b",
               busy, err, xerr);
    end
    checks++;
    if (fcnt != 0) begin
      errors++;
      $display("FAIL fifo_end got %0d want 0", fcnt);
    end
    if (n == 0) begin
      checks++;
      if (gcyc != 0) begin
        errors++;
        $display("FAIL len0_latency got %0d want 0", gcyc);
      end
    end
    set_idle();
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || err !== xerr) begin
      errors++;
      $display("FAIL done_pulse got %b err %b want 0 %b",
               done, err, xerr);
    end
  endtask

  task automatic test_reset();
    rstn = 0;
    set_idle();
    #3;
    checks++;
    if (outs() !== '0) begin
      errors++;
      $display("FAIL reset_in got %h want 0", outs());
    end
    do_reset();
    checks++;
    if (outs() !== '0) begin
      errors++;
      $display("FAIL reset_out got %h want 0", outs());
    end
  endtask

  task automatic test_basic();
    run_xfer(32'h1000, 32'h2000, 20, -1, 100);
  endtask

  task automatic test_4k();
    run_xfer(32'h0FF8, 32'h2000, 6, -1, 100);
    run_xfer(32'h3FF0, 32'h4FFC, 13, -1, 70);
  endtask

  task automatic test_fifo_gate();
    bit seen;
    fifo_cnt = 4'd12;
    ar_ready = 1;
    start_pulse(32'h0, 32'h100, 8);
    seen = 0;
    repeat (6) begin
      seen |= ar_valid;
      @(negedge clk);
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL ar_gate got 1 want 0");
    end
    fifo_cnt = 4'd7;
    ar_ready = 0;
    for (int i = 0; i < 4 && !ar_valid; i++)
      @(negedge clk);
    checks++;
    if ({ar_valid, ar_addr, ar_len} !==
        {1'b1, 32'h0, 8'd7}) begin
      errors++;
      $display("FAIL ar_open got %b %h %0d want 1 0 7",
               ar_valid, ar_addr, ar_len);
    end
    do_reset();
    fifo_cnt = 4'd3;
    start_pulse(32'h0, 32'h100, 4);
    seen = 0;
    repeat (6) begin
      seen |= aw_valid;
      @(negedge clk);
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL aw_gate got 1 want 0");
    end
    fifo_cnt = 4'd4;
    for (int i = 0; i < 4 && !aw_valid; i++)
      @(negedge clk);
    checks++;
    if ({aw_valid, aw_addr, aw_len} !==
        {1'b1, 32'h100, 8'd3}) begin
      errors++;
      $display("FAIL aw_open got %b %h %0d want 1 100 3",
               aw_valid, aw_addr, aw_len);
    end
    do_reset();
  endtask

  task automatic test_ar_stall();
    bit seen;
    start_pulse(32'h5000, 32'h6000, 16);
    for (int i = 0; i < 4 && !ar_valid; i++)
      @(negedge clk);
    repeat (5) begin
      r_beat = 1;
      checks++;
      if ({ar_valid, ar_addr, ar_len} !==
          {1'b1, 32'h5000, 8'd7}) begin
        errors++;
        $display("FAIL ar_hold got %b %h %0d want 1 5000 7",
                 ar_valid, ar_addr, ar_len);
      end
      @(negedge clk);
    end
    r_beat = 0;
    ar_ready = 1;
    @(negedge clk);
    ar_ready = 0;
    repeat (7) begin
      r_beat = 1;
      @(negedge clk);
    end
    r_beat = 0;
    seen = 0;
    repeat (3) begin
      seen |= ar_valid;
      @(negedge clk);
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL beat_count got early ar want none");
    end
    r_beat = 1;
    @(negedge clk);
    r_beat = 0;
    for (int i = 0; i < 3 && !ar_valid; i++)
      @(negedge clk);
    checks++;
    if ({ar_valid, ar_addr, ar_len} !==
        {1'b1, 32'h5020, 8'd7}) begin
      errors++;
      $display("FAIL ar_next got %b %h %0d want 1 5020 7",
               ar_valid, ar_addr, ar_len);
    end
    do_reset();
  endtask

  task automatic test_err();
    run_xfer(32'h1000, 32'h2000, 20, 1, 80);
    run_xfer(32'h1100, 32'h2100, 4, -1, 100);
  endtask

  task automatic test_reset_mid();
    ar_ready = 1;
    start_pulse(32'h3000, 32'h4000, 16);
    for (int i = 0; i < 4 && !ar_valid; i++)
      @(negedge clk);
    @(negedge clk);
    ar_ready = 0;
    r_beat = 1;
    @(negedge clk);
    @(negedge clk);
    #2 rstn = 0;
    #1;
    checks++;
    if (outs() !== '0) begin
      errors++;
      $display("FAIL reset_async got %h want 0", outs());
    end
    do_reset();
    run_xfer(32'h3000, 32'h4000, 16, -1, 70);
  endtask

  task automatic test_len0();
    run_xfer(32'h7000, 32'h8000, 0, -1, 100);
  endtask

  task automatic test_back_to_back();
    run_xfer(32'h0FE0, 32'h1FF4, 9, -1, 100);
    run_xfer(32'h9000, 32'hA004, 11, 0, 100);
  endtask

  task automatic test_random();
    logic [31:0] s, d;
    int n, bad, pr;
    for (int it = 0; it < 10; it++) begin
      s = {$urandom_range(255), 12'h0};
      d = {$urandom_range(255), 12'h0};
      s = s - 32'(4 * $urandom_range(0, 12));
      d = d + 32'(4 * $urandom_range(0, 1023));
      n = int'($urandom_range(1, 40));
      pr = int'($urandom_range(30, 100));
      bad = ($urandom_range(1) == 1) ?
            int'($urandom_range(0, 4)) : -1;
      run_xfer(s, d, n, bad, pr);
    end
  endtask

  initial begin
    set_idle();
    test_reset();
    test_basic();
    test_4k();
    test_fifo_gate();
    test_ar_stall();
    test_err();
    test_reset_mid();
    test_len0();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
